// File: rtl/scl_timer_pkg.sv
// Shared I2C slave constants and types used by the SCL timer and its neighbours.
package scl_timer_pkg;

   // Data bits per frame before the ACK slot.
   localparam int BITS_PER_BYTE = 8;
   // Wide enough to hold 0..BITS_PER_BYTE inclusive.
   localparam int CNT_W = $clog2(BITS_PER_BYTE + 1);

   typedef logic [CNT_W-1:0] bit_cnt_t;

   // SDA drive modes used by the controller / tx side of the slave.
   typedef enum logic [1:0] {
      SDA_RELEASE = 2'b00,
      SDA_ACK     = 2'b01,
      SDA_NACK    = 2'b10,
      SDA_DATA    = 2'b11
   } sda_mode_t;

   // Strobe bundle produced by the timer, one bit per controller event.
   typedef struct packed {
      logic rx_shift;
      logic tx_shift;
      logic byte_received;
      logic ack_prep;
      logic check_ack;
      logic ack_done;
   } strobes_t;

endpackage

// File: rtl/scl_timer_if.sv
// Detector-to-timer pulses and timer-to-controller strobes.
interface scl_timer_if;
   import scl_timer_pkg::*;

   logic     rising_edge_found;
   logic     falling_edge_found;
   logic     start_found;
   logic     stop_found;
   logic     rx_shift;
   logic     tx_shift;
   logic     byte_received;
   logic     ack_prep;
   logic     check_ack;
   logic     ack_done;
   bit_cnt_t bit_count;

   // Upstream side: drives bus events, observes the timing strobes.
   modport master (
      output rising_edge_found, falling_edge_found, start_found, stop_found,
      input  rx_shift, tx_shift, byte_received, ack_prep, check_ack, ack_done, bit_count
   );

   // Timer side: consumes bus events, produces the timing strobes.
   modport slave (
      input  rising_edge_found, falling_edge_found, start_found, stop_found,
      output rx_shift, tx_shift, byte_received, ack_prep, check_ack, ack_done, bit_count
   );

endinterface

// File: rtl/scl_timer_flex_counter.sv
// Saturating up-counter with synchronous clear and a look-ahead rollover flag.
module flex_counter #(
   parameter int NUM_BITS = 4
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                clear,
   input  logic                count_enable,
   input  logic [NUM_BITS-1:0] rollover_val,
   output logic [NUM_BITS-1:0] count_out,
   output logic                rollover_flag
);

   logic [NUM_BITS-1:0] count_q;
   logic [NUM_BITS-1:0] count_d;

   // Next count: clear wins, otherwise step up and stop at rollover_val (never wraps).
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (count_enable && (count_q != rollover_val)) begin
         count_d = count_q + NUM_BITS'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_out = count_q;
   // High when the next increment lands on rollover_val; depends only on the
   // register, so the FSM can register its strobe in the same cycle as the step.
   assign rollover_flag = (count_q == (rollover_val - NUM_BITS'(1)));

endmodule

// File: rtl/scl_timer.sv
// SCL bit/ACK timing generator: turns SCL edge and START/STOP pulses into
// registered one-cycle strobes for the slave controller and shift registers.
module scl_timer
   import scl_timer_pkg::*;
(
   input  logic        clk,
   input  logic        n_rst,
   scl_timer_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      START_WAIT = 3'd1,
      DATA       = 3'd2,
      BYTE_END   = 3'd3,
      ACK_LOW    = 3'd4,
      ACK_HIGH   = 3'd5
   } state_t;

   state_t   state_q, state_d;
   strobes_t strobes_q, strobes_d;
   logic     cnt_en;
   logic     cnt_clr;
   logic     cnt_roll;
   bit_cnt_t cnt_val;
   logic     rise;
   logic     fall;
   logic     edge_ok;

   assign rise    = bus.rising_edge_found;
   assign fall    = bus.falling_edge_found;
   // Simultaneous rise and fall is illegal on a real bus; treat it as no edge.
   assign edge_ok = !(rise && fall);

   // Data-bit counter; its look-ahead flag marks the rise that completes the byte.
   flex_counter #(
      .NUM_BITS (CNT_W)
   ) u_bit_cnt (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (cnt_clr),
      .count_enable  (cnt_en),
      .rollover_val  (bit_cnt_t'(BITS_PER_BYTE)),
      .count_out     (cnt_val),
      .rollover_flag (cnt_roll)
   );

   // Next state, next strobes and counter control; STOP beats START beats SCL edges.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
      state_d   = state_q;
      strobes_d = '0;
      cnt_en    = 1'b0;
      cnt_clr   = 1'b0;

      if (bus.stop_found) begin
         state_d = IDLE;
         cnt_clr = 1'b1;
      end else if (bus.start_found) begin
         state_d = START_WAIT;
         cnt_clr = 1'b1;
      end else if (edge_ok) begin
         unique case (state_q)
            IDLE: ;
            START_WAIT: begin
               if (fall) begin
                  state_d = DATA;
                  cnt_clr = 1'b1;
               end
            end
            DATA: begin
               if (rise) begin
                  strobes_d.rx_shift = 1'b1;
                  cnt_en             = 1'b1;
                  if (cnt_roll) begin
                     strobes_d.byte_received = 1'b1;
                     state_d                 = BYTE_END;
                  end
               end else if (fall && (cnt_val != '0)) begin
                  strobes_d.tx_shift = 1'b1;
               end
            end
            BYTE_END: begin
               if (fall) begin
                  strobes_d.ack_prep = 1'b1;
                  state_d            = ACK_LOW;
               end
            end
            ACK_LOW: begin
               if (rise) begin
                  strobes_d.check_ack = 1'b1;
                  state_d             = ACK_HIGH;
               end
            end
            ACK_HIGH: begin
               if (fall) begin
                  strobes_d.ack_done = 1'b1;
                  cnt_clr            = 1'b1;
                  state_d            = DATA;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State register and registered strobes.
   always_ff @(posedge clk or negedge n_rst) begin
      // NOTE: async reset clears state and strobes so a mid-frame reset drops all outputs immediately.
      if (!n_rst) begin
         state_q   <= IDLE;
         strobes_q <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values of the others.
         state_q   <= state_d;
         strobes_q <= strobes_d;
      end
   end

   assign bus.rx_shift      = strobes_q.rx_shift;
   assign bus.tx_shift      = strobes_q.tx_shift;
   assign bus.byte_received = strobes_q.byte_received;
   assign bus.ack_prep      = strobes_q.ack_prep;
   assign bus.check_ack     = strobes_q.check_ack;
   assign bus.ack_done      = strobes_q.ack_done;
   assign bus.bit_count     = cnt_val;

endmodule
